// File: rtl/fft_res_ram_wr_pkg.sv
// Shared definitions for the FFT result RAM writer and the cache slave that
// reads the same RAMs, so the RAM geometry is defined in one place.
package fft_res_ram_wr_pkg;

    localparam int unsigned C_FFT_SAMPLE_W   = 16;
    localparam int unsigned C_FFT_RAM_ADDR_W = 7;
    localparam int unsigned C_FFT_RAM_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DRAIN   = 2'd2
    } fft_wr_state_e;

endpackage

// File: rtl/fft_res_ram_wr_mag.sv
// fft_mag_approx: 3-stage magnitude approximation |z| ~ max + min/2.
// Valid, bin index and channel ride alongside the data.
module fft_mag_approx
    import fft_res_ram_wr_pkg::*;
#(
    parameter int P_W  = C_FFT_SAMPLE_W,
    parameter int P_AW = C_FFT_RAM_ADDR_W
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 vld_i,
    input  logic [P_W-1:0]       re_i,
    input  logic [P_W-1:0]       im_i,
    input  logic [P_AW-1:0]      bin_i,
    input  logic                 lchnl_i,
    output logic                 vld_o,
    output logic [P_W-1:0]       mag_o,
    output logic [P_AW-1:0]      bin_o,
    output logic                 lchnl_o,
    output logic                 busy_o
);

    localparam logic [P_W-1:0] C_POS_MAX = {1'b0, {(P_W-1){1'b1}}};
    localparam logic [P_W-1:0] C_NEG_MIN = {1'b1, {(P_W-1){1'b0}}};

    // Two's-complement abs; the most negative code has no positive twin,
    // so it clips to the largest positive value.
    function automatic logic [P_W-1:0] abs_sat(input logic [P_W-1:0] x);
        logic [P_W-1:0] r;
        if (x == C_NEG_MIN) begin
            r = C_POS_MAX;
        end else if (x[P_W-1]) begin
            r = (~x) + 1'b1;
        end else begin
            r = x;
        end
        return r;
    endfunction

    logic               s1_vld_q, s2_vld_q, s3_vld_q;
    logic [P_W-1:0]     s1_re_q, s1_im_q;
    logic [P_W-1:0]     s2_mx_q, s2_mn_q;
    logic [P_W-1:0]     s3_mag_q;
    logic [P_AW-1:0]    s1_bin_q, s2_bin_q, s3_bin_q;
    logic               s1_l_q, s2_l_q, s3_l_q;

    logic [P_W-1:0]     s1_re_d, s1_im_d;
    logic [P_W-1:0]     s2_mx_d, s2_mn_d;
    logic [P_W-1:0]     s3_mag_d;
    logic [P_W:0]       s3_sum;

    // Stage datapaths: abs, max/min sort, then add with saturation.
    always_comb begin
        s1_re_d  = abs_sat(re_i);
        s1_im_d  = abs_sat(im_i);
        s2_mx_d  = (s1_re_q >= s1_im_q) ? s1_re_q : s1_im_q;
        s2_mn_d  = (s1_re_q >= s1_im_q) ? s1_im_q : s1_re_q;
        s3_sum   = {1'b0, s2_mx_q} + {2'b00, s2_mn_q[P_W-1:1]};
        s3_mag_d = s3_sum[P_W] ? {P_W{1'b1}} : s3_sum[P_W-1:0];
    end

    // Pipeline registers; reset clears valids and the output stage.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_vld_q <= 1'b0;
            s2_vld_q <= 1'b0;
            s3_vld_q <= 1'b0;
            s1_re_q  <= '0;
            s1_im_q  <= '0;
            s2_mx_q  <= '0;
            s2_mn_q  <= '0;
            s3_mag_q <= '0;
            s1_bin_q <= '0;
            s2_bin_q <= '0;
            s3_bin_q <= '0;
            s1_l_q   <= 1'b0;
            s2_l_q   <= 1'b0;
            s3_l_q   <= 1'b0;
        end else begin
            s1_vld_q <= vld_i;
            s2_vld_q <= s1_vld_q;
            s3_vld_q <= s2_vld_q;
            s1_re_q  <= s1_re_d;
            s1_im_q  <= s1_im_d;
            s2_mx_q  <= s2_mx_d;
            s2_mn_q  <= s2_mn_d;
            s3_mag_q <= s3_mag_d;
            s1_bin_q <= bin_i;
            s2_bin_q <= s1_bin_q;
            s3_bin_q <= s2_bin_q;
            s1_l_q   <= lchnl_i;
            s2_l_q   <= s1_l_q;
            s3_l_q   <= s2_l_q;
        end
    end

    assign vld_o   = s3_vld_q;
    assign mag_o   = s3_mag_q;
    assign bin_o   = s3_bin_q;
    assign lchnl_o = s3_l_q;
    assign busy_o  = s1_vld_q | s2_vld_q | s3_vld_q;

endmodule

// File: rtl/fft_res_ram_wr.sv
// Writes the first 2**P_FFT_RAM_ADDR_W magnitude bins of each streamed FFT
// frame into the L or R result RAM and flags frame completion and errors.
//
// state   | meaning
// IDLE    | waiting for a valid SOP sample
// CAPTURE | in a frame; bins below the RAM depth go to the pipeline
// DRAIN   | EOP seen; waiting for the pipeline to empty before done
module fft_res_ram_wr
    import fft_res_ram_wr_pkg::*;
#(
    parameter int P_FFT_SAMPLE_W   = C_FFT_SAMPLE_W,
    parameter int P_FFT_RAM_ADDR_W = C_FFT_RAM_ADDR_W,
    parameter int P_FFT_RAM_DATA_W = C_FFT_RAM_DATA_W
) (
    input  logic                          av_clk_ir,
    input  logic                          av_rst_ih,
    input  logic                          fft_valid_ih,
    input  logic                          fft_sop_ih,
    input  logic                          fft_eop_ih,
    input  logic                          fft_lchnl_ih,
    input  logic [P_FFT_SAMPLE_W-1:0]     fft_re_id,
    input  logic [P_FFT_SAMPLE_W-1:0]     fft_im_id,
    output logic [P_FFT_RAM_ADDR_W-1:0]   fft_res_ram_wr_addr_od,
    output logic [P_FFT_RAM_DATA_W-1:0]   fft_res_ram_wr_data_od,
    output logic                          fft_res_ram_lchnl_wren_oh,
    output logic                          fft_res_ram_rchnl_wren_oh,
    output logic                          frame_done_oh,
    output logic                          frame_err_oh,
    output logic                          busy_oh
);

    localparam int AW = P_FFT_RAM_ADDR_W;

    fft_wr_state_e          state_q, state_d;
    logic [AW:0]            cnt_q, cnt_d;
    logic                   lchnl_q, lchnl_d;
    logic                   err_q, err_d;

    logic                   acc;
    logic [AW-1:0]          acc_bin;
    logic                   acc_l;
    logic                   done;
    logic                   idle_like;

    logic                   pipe_vld;
    logic [P_FFT_SAMPLE_W-1:0] pipe_mag;
    logic [AW-1:0]          pipe_bin;
    logic                   pipe_l;
    logic                   pipe_busy;

    // State, bin counter, latched channel and registered error pulse.
    always_ff @(posedge av_clk_ir) begin
        if (av_rst_ih) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            lchnl_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lchnl_q <= lchnl_d;
            err_q   <= err_d;
        end
    end

    // Next state and sample acceptance. DRAIN's exit cycle behaves as IDLE
    // so a back-to-back SOP is not lost.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        lchnl_d   = lchnl_q;
        err_d     = 1'b0;
        acc       = 1'b0;
        acc_bin   = cnt_q[AW-1:0];
        acc_l     = lchnl_q;
        done      = 1'b0;
        idle_like = 1'b0;

        case (state_q)
            ST_IDLE: begin
                idle_like = 1'b1;
            end
            ST_CAPTURE: begin
                if (fft_valid_ih) begin
                    if (fft_sop_ih && !fft_eop_ih) begin
                        // Unexpected SOP: report it and restart as a new frame.
                        err_d     = 1'b1;
                        idle_like = 1'b1;
                    end else begin
                        if (!cnt_q[AW]) begin
                            acc   = 1'b1;
                            cnt_d = cnt_q + 1'b1;
                        end
                        if (fft_eop_ih) begin
                            state_d = ST_DRAIN;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                if (!pipe_busy) begin
                    done      = 1'b1;
                    state_d   = ST_IDLE;
                    idle_like = 1'b1;
                end else if (fft_valid_ih) begin
                    err_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (idle_like && fft_valid_ih) begin
            if (fft_sop_ih) begin
                acc     = 1'b1;
                acc_bin = '0;
                acc_l   = fft_lchnl_ih;
                lchnl_d = fft_lchnl_ih;
                cnt_d   = (AW+1)'(1);
                state_d = fft_eop_ih ? ST_DRAIN : ST_CAPTURE;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    fft_mag_approx #(
        .P_W  (P_FFT_SAMPLE_W),
        .P_AW (AW)
    ) u_mag (
        .clk_i   (av_clk_ir),
        .rst_i   (av_rst_ih),
        .vld_i   (acc),
        .re_i    (fft_re_id),
        .im_i    (fft_im_id),
        .bin_i   (acc_bin),
        .lchnl_i (acc_l),
        .vld_o   (pipe_vld),
        .mag_o   (pipe_mag),
        .bin_o   (pipe_bin),
        .lchnl_o (pipe_l),
        .busy_o  (pipe_busy)
    );

    assign fft_res_ram_wr_addr_od    = pipe_bin;
    assign fft_res_ram_wr_data_od    = P_FFT_RAM_DATA_W'(pipe_mag);
    assign fft_res_ram_lchnl_wren_oh = pipe_vld & pipe_l;
    assign fft_res_ram_rchnl_wren_oh = pipe_vld & ~pipe_l;
    assign frame_done_oh             = done;
    assign frame_err_oh              = err_q;
    assign busy_oh                   = (state_q != ST_IDLE) | pipe_busy;

endmodule

// File: doc/fft_res_ram_wr.md
Name: fft_res_ram_wr

Overview:
- Upstream feeder of the FFT result RAMs that the Avalon cache slave reads.
- Accepts the streamed complex FFT output, one sample per valid cycle, tagged with a channel.
- Computes a magnitude approximation (max + min/2) in a 3-stage pipeline.
- Writes the first 2**P_FFT_RAM_ADDR_W bins of each frame into the L or R result RAM; signals frame completion and error conditions.

Parameters:
- P_FFT_SAMPLE_W, 16, signed width of FFT real/imag samples
- P_FFT_RAM_ADDR_W, 7, result RAM address width; bins stored per frame = 2**P_FFT_RAM_ADDR_W
- P_FFT_RAM_DATA_W, 32, result RAM data width; magnitude is zero-extended into it

Ports:
- av_clk_ir  in  1  single clock, rising edge
- av_rst_ih  in  1  synchronous reset, active-high
- fft_valid_ih  in  1  1 -> sample on fft_re_id/fft_im_id is valid this cycle
- fft_sop_ih  in  1  1 -> first sample of frame (qualified by valid)
- fft_eop_ih  in  1  1 -> last sample of frame (qualified by valid)
- fft_lchnl_ih  in  1  1 -> L channel frame, 0 -> R; sampled at SOP, held for frame
- fft_re_id  in  P_FFT_SAMPLE_W  signed real part
- fft_im_id  in  P_FFT_SAMPLE_W  signed imaginary part
- fft_res_ram_wr_addr_od  out  P_FFT_RAM_ADDR_W  write address, both RAMs
- fft_res_ram_wr_data_od  out  P_FFT_RAM_DATA_W  write data, both RAMs
- fft_res_ram_lchnl_wren_oh  out  1  write enable, L RAM
- fft_res_ram_rchnl_wren_oh  out  1  write enable, R RAM
- frame_done_oh  out  1  one-cycle pulse after the last write of a frame
- frame_err_oh  out  1  one-cycle pulse on a protocol error (see below)
- busy_oh  out  1  1 while state != IDLE or the pipeline holds valid data

Behaviour:
- Reset (av_rst_ih=1 at a clock edge): all outputs 0, FSM = IDLE, bin counter 0, pipeline valids cleared. Reset mid-frame abandons the frame; no further writes and no done pulse.
- FSM states:
  - IDLE: valid & SOP -> CAPTURE. Latch the channel and process the sample as bin 0. Valid without SOP is discarded and pulses frame_err_oh.
  - CAPTURE: each valid sample feeds the pipeline with bin index = counter, and the counter increments.
    - Once counter reaches 2**P_FFT_RAM_ADDR_W, further samples are discarded (not written) until EOP.
    - valid & EOP -> DRAIN.
    - valid & SOP (without EOP) -> frame_err_oh pulse; restart as a new frame (counter 0, relatch channel); already-written bins stay.
  - DRAIN: wait until the pipeline is empty, pulse frame_done_oh in the cycle after the last write, then -> IDLE. A valid sample arriving in DRAIN is treated as in IDLE the cycle DRAIN exits; earlier ones are discarded with frame_err_oh.
- SOP & EOP on the same sample: a 1-bin frame; bin 0 is written, then DRAIN.
- Pipeline (latency 3 cycles, input valid to wren):
  - S1: abs of re and im; -2**(W-1) saturates to 2**(W-1)-1.
  - S2: mx = max, mn = min.
  - S3: mag = mx + (mn >> 1) in W bits, saturated to 2**(W-1)-1 ... 2**W-1 as needed (result unsigned, W bits, saturate at 2**W-1); zero-extend to P_FFT_RAM_DATA_W.
- Bin index and channel travel with the data. Exactly one wren is high per written bin, selected by the latched channel. Address and data are valid in the same cycle as wren.
- No backpressure: the block accepts one sample per cycle indefinitely.

Decomposition:
- Shared package: FSM state encoding (IDLE, CAPTURE, DRAIN); default widths P_FFT_SAMPLE_W / P_FFT_RAM_ADDR_W / P_FFT_RAM_DATA_W, shared with the cache slave so the RAM geometry is defined once.
- One sub-module, fft_mag_approx: the 3-stage abs/max-min/add-saturate pipeline with valid, bin and channel sideband pass-through.

Test Plan:
- L frame, 128 valid samples, re=3, im=-4, SOP on first, EOP on last -> 128 L writes, addr 0..127, data 5 (4+3>>1), first wren 3 cycles after SOP, frame_done_oh 1 cycle after addr 127 write; R wren never high.
- R frame, 256 samples, EOP on 256th -> R writes only for addr 0..127; samples 128..255 are not written; one frame_done_oh.
- re=-32768, im=-32768 -> S1 gives 32767 each; data = 32767+16383 = 49150; re=im=0 -> 0.
- SOP at sample 10 with no EOP seen -> frame_err_oh pulse; next write is addr 0 with the newly latched channel.
- Valid without SOP in IDLE -> frame_err_oh, no wren; assert av_rst_ih at sample 50 of a frame -> all outputs 0 next cycle, no frame_done_oh.
- Single sample with SOP=EOP=1, re=10, im=2 -> one write, addr 0, data 11, then frame_done_oh.
